// File: rtl/fifo_sva_scoreboard_pkg.sv
// Shared types for the FIFO scoreboard: compare-field indices, FSM states and a
// saturating increment used by every counter.
package fifo_chk_pkg;

   typedef enum logic [2:0] {
      F_DATA   = 3'd0,
      F_FULL   = 3'd1,
      F_EMPTY  = 3'd2,
      F_AFULL  = 3'd3,
      F_AEMPTY = 3'd4,
      F_WACK   = 3'd5,
      F_OVF    = 3'd6,
      F_UDF    = 3'd7
   } chk_field_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_e;

   // Holds at the all-ones value of a width-bit counter instead of wrapping.
   function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
      logic [63:0] max_val;
      max_val = (64'd1 << width) - 64'd1;
      return (value == max_val) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/fifo_sva_scoreboard_if.sv
// Observed FIFO DUT pins: the stimulus the DUT receives and the outputs it produces.
interface fifo_sva_scoreboard_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almostfull;
   logic                  almostempty;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, rd_en, data_in, data_out, full, empty,
             almostfull, almostempty, wr_ack, overflow, underflow
   );

   modport slave (
      input  wr_en, rd_en, data_in, data_out, full, empty,
             almostfull, almostempty, wr_ack, overflow, underflow
   );
endinterface

// File: rtl/fifo_sva_scoreboard_ref_model.sv
// Shadow FIFO that follows the observed stimulus and produces the expected registered
// DUT outputs plus the occupancy the flag predictions are derived from.
module fifo_ref_model #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   localparam int PTR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dut_rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] exp_data_out,
   output logic                  exp_wr_ack,
   output logic                  exp_overflow,
   output logic                  exp_underflow,
   output logic                  exp_rd_acc,
   output logic [PTR_W:0]        count
);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]        count_reg;
   logic [DATA_WIDTH-1:0] data_out_reg;
   logic                  wr_ack_reg, overflow_reg, underflow_reg, rd_acc_reg;
   logic                  full_now, empty_now, wr_acc, rd_acc;

   assign full_now  = (count_reg == CNT_FULL);
   assign empty_now = (count_reg == '0);
   assign wr_acc    = wr_en && !full_now;
   assign rd_acc    = rd_en && !empty_now;

   // Storage carries no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (dut_rst_n && wr_acc) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         data_out_reg  <= '0;
         wr_ack_reg    <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         rd_acc_reg    <= 1'b0;
      end else if (!dut_rst_n) begin
         // DUT in reset: occupancy and strobes clear, the read register keeps its value.
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         wr_ack_reg    <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         rd_acc_reg    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
            data_out_reg <= mem[rd_ptr_reg];
         end
         if (wr_acc && !rd_acc) begin
            count_reg <= count_reg + CNT_ONE;
         end else if (rd_acc && !wr_acc) begin
            count_reg <= count_reg - CNT_ONE;
         end
         wr_ack_reg    <= wr_acc;
         overflow_reg  <= wr_en && full_now;
         underflow_reg <= rd_en && empty_now;
         rd_acc_reg    <= rd_acc;
      end
   end

   assign exp_data_out  = data_out_reg;
   assign exp_wr_ack    = wr_ack_reg;
   assign exp_overflow  = overflow_reg;
   assign exp_underflow = underflow_reg;
   assign exp_rd_acc    = rd_acc_reg;
   assign count         = count_reg;

endmodule

// File: rtl/fifo_sva_scoreboard.sv
// Cycle-accurate scoreboard for one synchronous FIFO: compares the DUT against a shadow
// model every enabled cycle and keeps sticky error bits, first-failure capture and counters.
module fifo_sva_scoreboard
   import fifo_chk_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 32,
   parameter int CHECK_DATA = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dut_rst_n,
   input  logic                 chk_en,
   input  logic                 test_done,
   fifo_sva_scoreboard_if.slave mon,
   output logic [7:0]           err_vec,
   output logic                 err_any,
   output logic [7:0]           first_err,
   output logic [CNT_WIDTH-1:0] first_cycle,
   output logic [CNT_WIDTH-1:0] error_cnt,
   output logic [CNT_WIDTH-1:0] correct_cnt,
   output logic                 report_valid
);
   localparam int            CW        = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AFULL = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [DATA_WIDTH-1:0] exp_data_out;
   logic                  exp_wr_ack, exp_overflow, exp_underflow, exp_rd_acc;
   logic [CW-1:0]         exp_count;
   logic [7:0]            mismatch;
   logic                  cmp_en, cmp_allowed;
   chk_state_e            state_reg, state_next;
   logic                  in_rst_cool_reg;
   logic [CNT_WIDTH-1:0]  cycle_cnt_reg, error_cnt_reg, correct_cnt_reg, first_cycle_reg;
   logic [7:0]            err_vec_reg, first_err_reg;

   fifo_ref_model #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ref_model (
      .clk           (clk),
      .rst_n         (rst_n),
      .dut_rst_n     (dut_rst_n),
      .wr_en         (mon.wr_en),
      .rd_en         (mon.rd_en),
      .data_in       (mon.data_in),
      .exp_data_out  (exp_data_out),
      .exp_wr_ack    (exp_wr_ack),
      .exp_overflow  (exp_overflow),
      .exp_underflow (exp_underflow),
      .exp_rd_acc    (exp_rd_acc),
      .count         (exp_count)
   );

   // data_out is only meaningful right after an accepted read; otherwise it is masked.
   always_comb begin
      mismatch           = '0;
      mismatch[F_DATA]   = (CHECK_DATA != 0) && exp_rd_acc && (mon.data_out != exp_data_out);
      mismatch[F_FULL]   = mon.full        != (exp_count == CNT_FULL);
      mismatch[F_EMPTY]  = mon.empty       != (exp_count == '0);
      mismatch[F_AFULL]  = mon.almostfull  != (exp_count == CNT_AFULL);
      mismatch[F_AEMPTY] = mon.almostempty != (exp_count == CNT_ONE);
      mismatch[F_WACK]   = mon.wr_ack      != exp_wr_ack;
      mismatch[F_OVF]    = mon.overflow    != exp_overflow;
      mismatch[F_UDF]    = mon.underflow   != exp_underflow;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (test_done) state_next = DONE;
                  else if (chk_en) state_next = RUN;
         RUN:     if (test_done) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      report_valid = test_done && (state_reg != DONE);
      cmp_allowed  = (state_reg != DONE);
   end

   assign cmp_en = chk_en && dut_rst_n && !in_rst_cool_reg && cmp_allowed;

   // in_rst_cool stays high through the first cycle after the DUT leaves reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_reg   <= '0;
         in_rst_cool_reg <= 1'b0;
         error_cnt_reg   <= '0;
         correct_cnt_reg <= '0;
         err_vec_reg     <= '0;
         first_err_reg   <= '0;
         first_cycle_reg <= '0;
      end else begin
         cycle_cnt_reg   <= CNT_WIDTH'(sat_inc(64'(cycle_cnt_reg), CNT_WIDTH));
         in_rst_cool_reg <= !dut_rst_n;
         if (cmp_en) begin
            if (mismatch != '0) begin
               error_cnt_reg <= CNT_WIDTH'(sat_inc(64'(error_cnt_reg), CNT_WIDTH));
               err_vec_reg   <= err_vec_reg | mismatch;
               if (err_vec_reg == '0) begin
                  first_err_reg   <= mismatch;
                  first_cycle_reg <= cycle_cnt_reg;
               end
            end else begin
               correct_cnt_reg <= CNT_WIDTH'(sat_inc(64'(correct_cnt_reg), CNT_WIDTH));
            end
         end
      end
   end

   assign err_vec     = err_vec_reg;
   assign err_any     = |err_vec_reg;
   assign first_err   = first_err_reg;
   assign first_cycle = first_cycle_reg;
   assign error_cnt   = error_cnt_reg;
   assign correct_cnt = correct_cnt_reg;

endmodule
